// File: rtl/cdb_arbiter_pkg.sv
// Shared Common Data Bus definitions used by the arbiter and by the execution units feeding it.
// Holds the default bus widths, the reserved "no tag" value and the broadcast packet layout.
package cdb_arbiter_pkg;

    localparam int CDB_N_REQ  = 4;
    localparam int CDB_TAG_W  = 8;
    localparam int CDB_DATA_W = 32;
    localparam int CDB_SRC_W  = 2;

    // ROB tag 0 is reserved: a result carrying it is never broadcast.
    localparam logic [CDB_TAG_W-1:0] NO_TAG = '0;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  index;
        logic [CDB_DATA_W-1:0] result;
        logic [CDB_SRC_W-1:0]  src;
    } cdb_pkt_t;

    function automatic logic [3:0] count_ones(input logic [7:0] vec);
        logic [3:0] total;
        total = '0;
        for (int i = 0; i < 8; i++) begin
            total = total + 4'(vec[i]);
        end
        return total;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Generic N-way round-robin picker: grants the first set request at or after i_ptr,
// wrapping modulo N, and returns both the one-hot grant and its encoded index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_pos;

    // Walk the requests in priority order starting at the pointer; first hit wins.
    always_comb begin
        o_grnt  = '0;
        o_idx   = '0;
        o_found = 1'b0;
        w_sum   = '0;
        w_pos   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N)) begin
                w_sum = w_sum - (IDX_W+1)'(N);
            end
            w_pos = w_sum[IDX_W-1:0];
            if (!o_found && i_req[w_pos]) begin
                o_found       = 1'b1;
                o_grnt[w_pos] = 1'b1;
                o_idx         = w_pos;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin grant in cycle t, capture of the winner's result in t+1, broadcast in t+2.
// Defining CDB_PERF_CNT_EN adds broadcast, bubble and request-conflict performance counters.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ  = CDB_N_REQ,
    parameter int TAG_W  = CDB_TAG_W,
    parameter int DATA_W = CDB_DATA_W,
    parameter int SRC_W  = CDB_SRC_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_br,
    input  logic [N_REQ-1:0]        i_req,
    output logic [N_REQ-1:0]        o_grnt,
    input  logic [N_REQ-1:0]        i_unit_valid,
    input  logic [N_REQ*TAG_W-1:0]  i_unit_index,
    input  logic [N_REQ*DATA_W-1:0] i_unit_result,
    output logic                    o_cdb_valid,
    output logic [TAG_W-1:0]        o_cdb_index,
    output logic [DATA_W-1:0]       o_cdb_result,
    output logic [SRC_W-1:0]        o_cdb_src
`ifdef CDB_PERF_CNT_EN
    ,
    output logic [31:0]             o_perf_bcast,
    output logic [31:0]             o_perf_bubble,
    output logic [31:0]             o_perf_conflict
`endif
);

    logic [SRC_W-1:0]  r_rr_ptr;
    logic [N_REQ-1:0]  r_gnt_q;
    logic [SRC_W-1:0]  r_gnt_idx;
    logic              r_cdb_valid;
    logic [TAG_W-1:0]  r_cdb_index;
    logic [DATA_W-1:0] r_cdb_result;
    logic [SRC_W-1:0]  r_cdb_src;

    logic [N_REQ-1:0]  w_arb_req;
    logic [N_REQ-1:0]  w_grnt;
    logic [SRC_W-1:0]  w_arb_idx;
    logic              w_found;
    logic [SRC_W-1:0]  w_next_ptr;
    logic              w_sel_valid;
    logic              w_deliver;
    logic [TAG_W-1:0]  w_unit_index  [N_REQ];
    logic [DATA_W-1:0] w_unit_result [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_unit_index[g]  = i_unit_index[g*TAG_W +: TAG_W];
        assign w_unit_result[g] = i_unit_result[g*DATA_W +: DATA_W];
    end

    // A mispredict suppresses arbitration entirely, so no unit is told to drive during a flush.
    assign w_arb_req = i_req & {N_REQ{~i_br}};

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (SRC_W)
    ) u_rr_arbiter (
        .i_req   (w_arb_req),
        .i_ptr   (r_rr_ptr),
        .o_grnt  (w_grnt),
        .o_idx   (w_arb_idx),
        .o_found (w_found)
    );

    assign o_grnt     = w_grnt & {N_REQ{~i_rst}};
    assign w_next_ptr = (w_arb_idx == SRC_W'(N_REQ - 1)) ? '0 : w_arb_idx + 1'b1;

    // Only the unit granted last cycle is listened to; a zero tag marks an empty slot.
    assign w_sel_valid = i_unit_valid[r_gnt_idx];
    assign w_deliver   = (r_gnt_q != '0) && w_sel_valid
                         && (w_unit_index[r_gnt_idx] != TAG_W'(NO_TAG));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rr_ptr     <= '0;
            r_gnt_q      <= '0;
            r_gnt_idx    <= '0;
            r_cdb_valid  <= 1'b0;
            r_cdb_index  <= '0;
            r_cdb_result <= '0;
            r_cdb_src    <= '0;
        end else if (i_br) begin
            r_gnt_q     <= '0;
            r_cdb_valid <= 1'b0;
        end else begin
            r_gnt_q     <= w_grnt;
            r_gnt_idx   <= w_arb_idx;
            r_cdb_valid <= w_deliver;
            if (w_found) begin
                r_rr_ptr <= w_next_ptr;
            end
            if (w_deliver) begin
                r_cdb_index  <= w_unit_index[r_gnt_idx];
                r_cdb_result <= w_unit_result[r_gnt_idx];
                r_cdb_src    <= r_gnt_idx;
            end
        end
    end

    assign o_cdb_valid  = r_cdb_valid;
    assign o_cdb_index  = r_cdb_index;
    assign o_cdb_result = r_cdb_result;
    assign o_cdb_src    = r_cdb_src;

`ifdef CDB_PERF_CNT_EN
    logic [31:0] r_perf_bcast;
    logic [31:0] r_perf_bubble;
    logic [31:0] r_perf_conflict;
    logic        w_conflict;

    assign w_conflict = count_ones(8'(i_req)) > 4'd1;

    // Counters survive a flush; a capture dropped by the flush is not a bubble.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_perf_bcast    <= '0;
            r_perf_bubble   <= '0;
            r_perf_conflict <= '0;
        end else begin
            if (r_cdb_valid) begin
                r_perf_bcast <= r_perf_bcast + 32'd1;
            end
            if (!i_br && (r_gnt_q != '0) && !w_deliver) begin
                r_perf_bubble <= r_perf_bubble + 32'd1;
            end
            if (w_conflict) begin
                r_perf_conflict <= r_perf_conflict + 32'd1;
            end
        end
    end

    assign o_perf_bcast    = r_perf_bcast;
    assign o_perf_bubble   = r_perf_bubble;
    assign o_perf_conflict = r_perf_conflict;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus pushes expected broadcasts, a monitor pops and compares.
module tb_cdb_arbiter;

    typedef struct {
        logic [7:0]  idx;
        logic [31:0] res;
        logic [1:0]  src;
    } expT;

    logic         clk = 1'b0;
    logic         rst;
    logic         br;
    logic [3:0]   req;
    logic [3:0]   grnt;
    logic [3:0]   uValid;
    logic [31:0]  uIndex;
    logic [127:0] uResult;
    logic         cdbValid;
    logic [7:0]   cdbIndex;
    logic [31:0]  cdbResult;
    logic [1:0]   cdbSrc;

    expT expQ[$];
    expT popped;
    int  total = 0;
    int  bad   = 0;

    logic [3:0] fairExp [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};

`ifdef CDB_PERF_CNT_EN
    logic [31:0] perfBcast;
    logic [31:0] perfBubble;
    logic [31:0] perfConflict;
`endif

    cdb_arbiter dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_br          (br),
        .i_req         (req),
        .o_grnt        (grnt),
        .i_unit_valid  (uValid),
        .i_unit_index  (uIndex),
        .i_unit_result (uResult),
        .o_cdb_valid   (cdbValid),
        .o_cdb_index   (cdbIndex),
        .o_cdb_result  (cdbResult),
        .o_cdb_src     (cdbSrc)
`ifdef CDB_PERF_CNT_EN
        ,
        .o_perf_bcast    (perfBcast),
        .o_perf_bubble   (perfBubble),
        .o_perf_conflict (perfConflict)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] reqV, input logic brV);
        @(posedge clk);
        #1;
        req     = reqV;
        br      = brV;
        uValid  = '0;
        uIndex  = '0;
        uResult = '0;
    endtask

    task automatic unitDrive(input int u, input logic v, input logic [7:0] tag, input logic [31:0] data);
        uValid[u]            = v;
        uIndex[u*8 +: 8]     = tag;
        uResult[u*32 +: 32]  = data;
    endtask

    task automatic pushExp(input logic [7:0] tag, input logic [31:0] data, input logic [1:0] src);
        expT e;
        e.idx = tag;
        e.res = data;
        e.src = src;
        expQ.push_back(e);
    endtask

    task automatic checkGrant(input string name, input logic [3:0] want);
        #2;
        checkOutput(name, 32'(grnt), 32'(want));
    endtask

    // Monitor: every broadcast must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && cdbValid) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_bcast: got idx=%h res=%h src=%0d want no broadcast",
                             cdbIndex, cdbResult, cdbSrc);
                end else begin
                    popped = expQ.pop_front();
                    checkOutput("bcast_index", 32'(cdbIndex), 32'(popped.idx));
                    checkOutput("bcast_result", cdbResult, popped.res);
                    checkOutput("bcast_src", 32'(cdbSrc), 32'(popped.src));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; br = 1'b0; req = 4'b1111;
        uValid = '0; uIndex = '0; uResult = '0;

        // Reset held with all units requesting
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_grnt", 32'(grnt), 32'h0);
        checkOutput("rst_valid", 32'(cdbValid), 32'h0);
        checkOutput("rst_index", 32'(cdbIndex), 32'h0);
        checkOutput("rst_src", 32'(cdbSrc), 32'h0);
        req = 4'b0000;
        rst = 1'b0;

        // Fairness: all four request for 8 cycles, each granted unit delivers next cycle
        for (int k = 0; k < 9; k++) begin
            applyStimulus((k < 8) ? 4'b1111 : 4'b0000, 1'b0);
            if (k > 0) begin
                unitDrive((k - 1) % 4, 1'b1, 8'(k), 32'hA000_0000 + 32'(k));
                pushExp(8'(k), 32'hA000_0000 + 32'(k), 2'((k - 1) % 4));
            end
            checkGrant("fair_grant", fairExp[k]);
        end
        applyStimulus(4'b0000, 1'b0);

        // Single request from unit 1
        applyStimulus(4'b0010, 1'b0);
        checkGrant("single_grant", 4'b0010);
        applyStimulus(4'b0000, 1'b0);
        unitDrive(1, 1'b1, 8'h05, 32'hDEAD_BEEF);
        pushExp(8'h05, 32'hDEAD_BEEF, 2'd1);
        checkGrant("single_idle", 4'b0000);
        repeat (2) applyStimulus(4'b0000, 1'b0);

        // Bubble (valid=0) and tag 0 both yield no broadcast
        applyStimulus(4'b0100, 1'b0);
        checkGrant("bubble_grant2", 4'b0100);
        applyStimulus(4'b1000, 1'b0);
        unitDrive(2, 1'b0, 8'h21, 32'h2121_2121);
        checkGrant("bubble_grant3", 4'b1000);
        applyStimulus(4'b0000, 1'b0);
        unitDrive(3, 1'b1, 8'h00, 32'h0000_BAD0);
        checkGrant("bubble_idle", 4'b0000);
        repeat (2) applyStimulus(4'b0000, 1'b0);

        // Flush drops unit 2's capture and keeps the pointer at 3
        applyStimulus(4'b0100, 1'b0);
        checkGrant("flush_pre_grant", 4'b0100);
        applyStimulus(4'b1000, 1'b1);
        unitDrive(2, 1'b1, 8'h33, 32'h3333_3333);
        checkGrant("flush_grant", 4'b0000);
        applyStimulus(4'b1001, 1'b0);
        checkGrant("flush_post_grant", 4'b1000);
        applyStimulus(4'b0000, 1'b0);
        unitDrive(3, 1'b1, 8'h44, 32'h4444_4444);
        pushExp(8'h44, 32'h4444_4444, 2'd3);
        repeat (2) applyStimulus(4'b0000, 1'b0);

        // Foreign valid from unit 3 must be ignored
        applyStimulus(4'b0001, 1'b0);
        checkGrant("foreign_grant", 4'b0001);
        applyStimulus(4'b0000, 1'b0);
        unitDrive(0, 1'b1, 8'h11, 32'h1111_1111);
        unitDrive(3, 1'b1, 8'h99, 32'h9999_9999);
        pushExp(8'h11, 32'h1111_1111, 2'd0);
        repeat (2) applyStimulus(4'b0000, 1'b0);

        // Two persistent requesters alternate from pointer 1
        applyStimulus(4'b0011, 1'b0);
        checkGrant("pair_grant_a", 4'b0010);
        applyStimulus(4'b0011, 1'b0);
        unitDrive(1, 1'b1, 8'h71, 32'h7171_0001);
        pushExp(8'h71, 32'h7171_0001, 2'd1);
        checkGrant("pair_grant_b", 4'b0001);
        applyStimulus(4'b0011, 1'b0);
        unitDrive(0, 1'b1, 8'h72, 32'h7272_0002);
        pushExp(8'h72, 32'h7272_0002, 2'd0);
        checkGrant("pair_grant_c", 4'b0010);
        applyStimulus(4'b0000, 1'b0);
        unitDrive(1, 1'b1, 8'h73, 32'h7373_0003);
        pushExp(8'h73, 32'h7373_0003, 2'd1);
        repeat (2) applyStimulus(4'b0000, 1'b0);

        // Asynchronous reset while a broadcast is on the bus
        applyStimulus(4'b0100, 1'b0);
        checkGrant("arst_pre_grant", 4'b0100);
        applyStimulus(4'b0000, 1'b0);
        unitDrive(2, 1'b1, 8'h55, 32'h5555_5555);
        @(posedge clk);
        #2;
        checkOutput("arst_pre_valid", 32'(cdbValid), 32'h1);
        rst = 1'b1;
        req = 4'b1111;
        #1;
        checkOutput("arst_valid", 32'(cdbValid), 32'h0);
        checkOutput("arst_grnt", 32'(grnt), 32'h0);
        req = 4'b0000;
        rst = 1'b0;
        applyStimulus(4'b1111, 1'b0);
        checkGrant("post_rst_grant", 4'b0001);
        applyStimulus(4'b0000, 1'b0);
        unitDrive(0, 1'b1, 8'h66, 32'h6666_6666);
        pushExp(8'h66, 32'h6666_6666, 2'd0);
        repeat (3) applyStimulus(4'b0000, 1'b0);

        checkOutput("queue_empty", 32'(expQ.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
